// File: rtl/conv1_pkg.sv
// Shared constants, address widths and state encoding for the conv1 layer
// (sequencer, execute stage and f2 memory wrapper).
package conv1_pkg;

  localparam int IMG_W  = 32;
  localparam int K      = 5;
  localparam int OUT_W  = IMG_W - K + 1;
  localparam int WB_LAT = 3;

  localparam int IMG_AW = 10;
  localparam int F2_AW  = 10;
  localparam int WIDX_W = 5;
  localparam int RC_W   = 5;
  localparam int KC_W   = 3;

  typedef logic [RC_W-1:0] rc_t;
  typedef logic [KC_W-1:0] kc_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  function automatic logic [IMG_AW-1:0] img_addr(rc_t r, rc_t c, kc_t kr, kc_t kc);
    return IMG_AW'((32'(r) + 32'(kr)) * IMG_W + 32'(c) + 32'(kc));
  endfunction

  function automatic logic [F2_AW-1:0] f2_addr(rc_t r, rc_t c);
    return F2_AW'(32'(r) * OUT_W + 32'(c));
  endfunction

  function automatic logic [WIDX_W-1:0] tap_idx(kc_t kr, kc_t kc);
    return WIDX_W'(32'(kr) * K + 32'(kc));
  endfunction

endpackage

// File: rtl/conv1_wb_pipe.sv
// Valid+address delay line that lines up the f2 write with the pixel result
// emerging from the MAC/execute pipeline.
module conv1_wb_pipe #(
  parameter int DEPTH = 3,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          clr_i,
  input  logic          vld_i,
  input  logic [AW-1:0] addr_i,
  output logic          vld_o,
  output logic [AW-1:0] addr_o
);

  logic          vld_q  [DEPTH];
  logic [AW-1:0] addr_q [DEPTH];

  // NOTE: the whole line is cleared, not just the valid bits, so the write
  // address reads back as 0 after reset like every other output.
  always_ff @(posedge clk) begin
    if (clr_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        vld_q[i]  <= 1'b0;
        addr_q[i] <= '0;
      end
    end else begin
      vld_q[0]  <= vld_i;
      addr_q[0] <= addr_i;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i]  <= vld_q[i-1];
        addr_q[i] <= addr_q[i-1];
      end
    end
  end

  assign vld_o  = vld_q[DEPTH-1];
  assign addr_o = addr_q[DEPTH-1];

endmodule

// File: rtl/conv1_ctrl.sv
// conv1 sequencer: walks the 28x28 output map with a 5x5 window, one tap per
// cycle, and schedules the f2 write of each finished pixel.
module conv1_ctrl
  import conv1_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              hold,
  output logic              busy,
  output logic              done,
  output logic [IMG_AW-1:0] img_raddr,
  output logic [WIDX_W-1:0] w_idx,
  output logic              tap_vld,
  output logic              mac_clr,
  output logic              f2_we,
  output logic [F2_AW-1:0]  f2_waddr
);

  state_e            state_q;
  rc_t               r_q, c_q;
  kc_t               kr_q, kc_q;
  logic              tap_last_q;
  logic [F2_AW-1:0]  pix_addr_q;

  logic issue, kc_last, kr_last, c_last, r_last, pix_last, layer_last;

  // A tap is issued on the start edge itself so the first tap shows up one cycle later.
  assign issue      = (state_q == S_IDLE && start) || (state_q == S_RUN && !hold);
  assign kc_last    = (kc_q == KC_W'(K - 1));
  assign kr_last    = (kr_q == KC_W'(K - 1));
  assign c_last     = (c_q == RC_W'(OUT_W - 1));
  assign r_last     = (r_q == RC_W'(OUT_W - 1));
  assign pix_last   = kc_last && kr_last;
  assign layer_last = pix_last && c_last && r_last;

  // NOTE: all state and output registers use non-blocking assignments so every
  // right-hand side sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      r_q        <= '0;
      c_q        <= '0;
      kr_q       <= '0;
      kc_q       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      tap_vld    <= 1'b0;
      mac_clr    <= 1'b0;
      img_raddr  <= '0;
      w_idx      <= '0;
      tap_last_q <= 1'b0;
      pix_addr_q <= '0;
    end else begin
      tap_vld    <= issue;
      mac_clr    <= issue && kr_q == '0 && kc_q == '0;
      tap_last_q <= issue && pix_last;
      done       <= 1'b0;

      if (issue) begin
        img_raddr  <= img_addr(r_q, c_q, kr_q, kc_q);
        w_idx      <= tap_idx(kr_q, kc_q);
        pix_addr_q <= f2_addr(r_q, c_q);
        kc_q       <= kc_last ? '0 : kc_q + 1'b1;
        if (kc_last) begin
          kr_q <= kr_last ? '0 : kr_q + 1'b1;
          if (kr_last) begin
            c_q <= c_last ? '0 : c_q + 1'b1;
            if (c_last) r_q <= r_last ? '0 : r_q + 1'b1;
          end
        end
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_RUN;
            busy    <= 1'b1;
          end
        end
        S_RUN: begin
          if (issue && layer_last) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          // Only the final pixel's write can still be in flight here.
          if (f2_we) begin
            state_q <= S_DONE;
            done    <= 1'b1;
            busy    <= 1'b0;
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  conv1_wb_pipe #(
    .DEPTH (WB_LAT),
    .AW    (F2_AW)
  ) u_wb_pipe (
    .clk    (clk),
    .clr_i  (rst),
    .vld_i  (tap_last_q),
    .addr_i (pix_addr_q),
    .vld_o  (f2_we),
    .addr_o (f2_waddr)
  );

endmodule

// File: tb/tb_conv1_ctrl.sv
// Self-checking bench for conv1_ctrl: tap-sequence model, f2 write scoreboard,
// table vectors for key taps, and hold / restart / mid-run reset sequences.
module tb_conv1_ctrl;
  import conv1_pkg::*;

  logic              clk, rst, start, hold;
  logic              busy, done, tap_vld, mac_clr, f2_we;
  logic [IMG_AW-1:0] img_raddr;
  logic [WIDX_W-1:0] w_idx;
  logic [F2_AW-1:0]  f2_waddr;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  localparam int TAPS   = OUT_W * OUT_W * K * K;
  localparam int PIXELS = OUT_W * OUT_W;

  typedef struct {
    int          cyc;
    logic [9:0]  addr;
    logic [4:0]  widx;
    logic        clr;
  } tap_vec_t;

  typedef struct {
    int         cyc;
    logic [9:0] addr;
  } wr_t;

  tap_vec_t vec [5];

  conv1_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .hold      (hold),
    .busy      (busy),
    .done      (done),
    .img_raddr (img_raddr),
    .w_idx     (w_idx),
    .tap_vld   (tap_vld),
    .mac_clr   (mac_clr),
    .f2_we     (f2_we),
    .f2_waddr  (f2_waddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, want);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, " busy"},      busy, 0);
    check({tag, " done"},      done, 0);
    check({tag, " tap_vld"},   tap_vld, 0);
    check({tag, " mac_clr"},   mac_clr, 0);
    check({tag, " f2_we"},     f2_we, 0);
    check({tag, " img_raddr"}, img_raddr, 0);
    check({tag, " w_idx"},     w_idx, 0);
    check({tag, " f2_waddr"},  f2_waddr, 0);
  endtask

  // One full layer from a start pulse; the bench tracks its own r/c/kr/kc.
  task automatic run_layer(input int hold_at, input int hold_len, input int restart_at,
                           input bit use_table, output int done_obs);
    int r, c, kr, kc, n_taps, exp_done, n_writes;
    logic issue, e_vld, e_clr;
    logic [9:0] e_addr;
    logic [4:0] e_widx;
    wr_t q[$];
    wr_t w;
    r = 0; c = 0; kr = 0; kc = 0; n_taps = 0; n_writes = 0;
    exp_done = 1 << 30; done_obs = -1;
    e_addr = '0; e_widx = '0;
    cyc = 0; start = 1'b1; hold = 1'b0; issue = 1'b1;
    forever begin
      e_vld = issue;
      e_clr = 1'b0;
      if (issue) begin
        e_addr = 10'((r + kr) * IMG_W + c + kc);
        e_widx = 5'(kr * K + kc);
        e_clr  = (kr == 0 && kc == 0);
        n_taps++;
        if (kr == K - 1 && kc == K - 1) q.push_back('{cyc + 1 + WB_LAT, 10'(r * OUT_W + c)});
        if (n_taps == TAPS) exp_done = cyc + 1 + WB_LAT + 1;
        kc++;
        if (kc == K) begin
          kc = 0; kr++;
          if (kr == K) begin
            kr = 0; c++;
            if (c == OUT_W) begin c = 0; r++; end
          end
        end
      end
      @(negedge clk);
      cyc++;
      check("tap", {15'd0, tap_vld, mac_clr, w_idx, img_raddr},
                   {15'd0, e_vld, e_clr, e_widx, e_addr});
      if (use_table)
        foreach (vec[i])
          if (vec[i].cyc == cyc)
            check("table tap", {15'd0, tap_vld, mac_clr, w_idx, img_raddr},
                               {15'd0, 1'b1, vec[i].clr, vec[i].widx, vec[i].addr});
      if (q.size() > 0 && q[0].cyc == cyc) begin
        w = q.pop_front();
        check("f2 write", {21'd0, f2_we, f2_waddr}, {21'd0, 1'b1, w.addr});
      end else begin
        check("f2_we idle", f2_we, 0);
      end
      n_writes += int'(f2_we);
      if (done) done_obs = cyc;
      check("busy", busy, (cyc < exp_done) ? 1 : 0);
      check("done", done, (cyc == exp_done) ? 1 : 0);
      start = (cyc == restart_at) || (cyc == exp_done);
      hold  = (cyc >= hold_at) && (cyc < hold_at + hold_len);
      if (cyc == exp_done) break;
      if (cyc > 30000) begin
        check("layer finish timeout", cyc, exp_done);
        break;
      end
      issue = (n_taps < TAPS) && !hold;
    end
    @(negedge clk);
    cyc++;
    start = 1'b0;
    hold  = 1'b0;
    check("start in DONE ignored", {busy, tap_vld, done}, 0);
    check("f2 write count", n_writes, PIXELS);
  endtask

  int done_cyc;

  initial begin
    vec[0] = '{1,     10'd0,    5'd0,  1'b1};
    vec[1] = '{6,     10'd32,   5'd5,  1'b0};
    vec[2] = '{25,    10'd132,  5'd24, 1'b0};
    vec[3] = '{26,    10'd1,    5'd0,  1'b1};
    vec[4] = '{TAPS,  10'd1023, 5'd24, 1'b0};

    rst = 1'b1; start = 1'b0; hold = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    @(negedge clk);

    // Plain run, with a second start pulse while busy that must be ignored.
    run_layer(0, 0, 500, 1'b1, done_cyc);
    check("done cycle (no hold)", done_cyc, TAPS + 1 + WB_LAT);

    // Reset in the middle of pixel 100.
    repeat (2) @(negedge clk);
    cyc = 0; start = 1'b1;
    @(negedge clk);
    cyc++; start = 1'b0;
    repeat (2503) begin @(negedge clk); cyc++; end
    rst = 1'b1;
    @(negedge clk);
    cyc++;
    check_reset("mid-run reset");
    rst = 1'b0;
    repeat (40) begin
      @(negedge clk);
      cyc++;
      check("quiet after reset", {busy, done, tap_vld, f2_we}, 0);
    end

    // Fresh start replays from address 0, with a 10-cycle hold mid-pixel.
    run_layer(110, 10, 0, 1'b0, done_cyc);
    check("done cycle (hold 10)", done_cyc, TAPS + 1 + WB_LAT + 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
